// File: rtl/word_executor.sv
// Word executor: fetches 12-bit control words from a program sequencer and
// drives the channel enables for a coded number of duration ticks per word.
module word_executor #(
    parameter int TICK_DIV  = 1000,
    parameter int SETTLE    = 2,
    parameter int MAX_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] data,
    output logic        go,
    output logic [3:0]  chan,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [4:0]  step,
    output logic [2:0]  fsm_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [4:0]    STEP_MAX    = 5'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_SETTLE = 3'd2,
        S_LOAD   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [PW-1:0]   pre_cnt;
    logic [4:0]      tick_cnt;
    logic            unused_bits;

    // Word bits [3:1] carry no meaning for this block.
    assign unused_bits = ^data[3:1];
    assign fsm_state   = 3'(state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            go         <= 1'b0;
            chan       <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            step       <= 5'd0;
            settle_cnt <= '0;
            pre_cnt    <= '0;
            tick_cnt   <= 5'd0;
        end else begin
            go   <= 1'b0;
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                chan       <= 4'd0;
                busy       <= 1'b0;
                settle_cnt <= '0;
                pre_cnt    <= '0;
                tick_cnt   <= 5'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state <= S_REQ;
                            go    <= 1'b1;
                            busy  <= 1'b1;
                            step  <= 5'd0;
                            err   <= 1'b0;
                        end
                    end
                    S_REQ: begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_INIT;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_ONE) begin
                            state <= S_LOAD;
                        end else begin
                            settle_cnt <= settle_cnt - SETTLE_ONE;
                        end
                    end
                    S_LOAD: begin
                        if (data[0]) begin
                            state <= S_IDLE;
                            chan  <= 4'd0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_HOLD;
                            chan     <= data[11:8];
                            tick_cnt <= {1'b0, data[7:4]} + 5'd1;
                            pre_cnt  <= '0;
                            step     <= step + 5'd1;
                        end
                    end
                    S_HOLD: begin
                        // The tick counter is loaded with code+1, so the word
                        // ends on the prescaler wrap that sees it at one.
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= '0;
                            if (tick_cnt == 5'd1) begin
                                tick_cnt <= 5'd0;
                                if (step >= STEP_MAX) begin
                                    state <= S_IDLE;
                                    err   <= 1'b1;
                                    chan  <= 4'd0;
                                    busy  <= 1'b0;
                                end else begin
                                    state <= S_REQ;
                                    go    <= 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt - 5'd1;
                            end
                        end else begin
                            pre_cnt <= pre_cnt + PW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        chan  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
